// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding and counter sizing
package serial_subtractor_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: one-bit combinational subtract cell with borrow in/out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with borrow-out and signed overflow
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, nxt;
    logic [WIDTH-1:0] sa, sb, r;
    logic [CW-1:0] count;
    logic br, a_msb, b_msb, d, bo, last;
    full_subtractor u_fs (.x(sa[0]), .y(sb[0]), .bin(br), .d(d), .bo(bo));
    assign last = count == CW'(WIDTH - 1);
    always_comb begin
        nxt  = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
        busy = state == SHIFT;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            r     <= '0;
            count <= '0;
            br    <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                sa    <= a;
                sb    <= b;
                br    <= 1'b0;
                count <= '0;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == SHIFT) begin
                br    <= bo;
                r     <= {d, r[WIDTH-1:1]};
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                count <= count + 1'b1;
                // outputs only update here so partial results never leak
                if (last) begin
                    diff <= {d, r[WIDTH-1:1]};
                    bout <= bo;
                    ovf  <= (a_msb != b_msb) && (d != a_msb);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for the bit-serial subtractor
module tb_serial_subtractor;
    localparam int W = 8;
    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] a = '0, b = '0, diff;
    logic busy, done, bout, ovf;
    int n_tests = 0, n_fail = 0, n_done = 0;
    int m_st = 0, m_cnt = 0;
    logic m_rst = 1'b1;
    res_t q[$];
    res_t e = '0;
    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t o;
        int sd;
        sd     = $signed(x) - $signed(y);
        o.diff = W'(x - y);
        o.bout = x < y;
        o.ovf  = sd > 127 || sd < -128;
        return o;
    endfunction
    // reference timing model: expectations pushed at each modelled acceptance
    always @(posedge clk) begin
        m_rst <= rst;
        if (rst) m_st <= 0;
        else if (m_st == 0) begin
            if (start) begin
                q.push_back(ref_sub(a, b));
                m_st  <= 1;
                m_cnt <= 0;
            end
        end else if (m_st == 1) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == W - 1) m_st <= 2;
        end else m_st <= 0;
    end
    always @(negedge clk) begin
        if (m_rst) begin
            q.delete();
            e = '0;
        end
        chk("busy", busy, m_st == 1);
        chk("done", done, m_st == 2);
        if (m_st == 2) begin
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) e = q.pop_front();
        end
        if (done) n_done++;
        chk("diff", diff, e.diff);
        chk("bout", bout, e.bout);
        chk("ovf", ovf, e.ovf);
    end
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic [W-1:0] ed,
                          input logic eb, input logic eo, input logic noise);
        int n;
        a = oa;
        b = ob;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (n = 1; n <= W + 3; n++) begin
            @(negedge clk);
            if (done) break;
            start = noise;
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        chk("latency", n, W + 1);
        chk("op_diff", diff, ed);
        chk("op_bout", bout, eb);
        chk("op_ovf", ovf, eo);
        @(posedge clk);
        #1;
    endtask
    initial begin
        int d0;
        res_t r;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        @(posedge clk);
        #1;
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op(8'h37, 8'h37, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
        d0 = n_done;
        start = 1'b1;
        repeat (40) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("cont_ops", n_done - d0, 4);
        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0);
        a = 8'hC3;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        chk("abort_ovf", ovf, 0);
        d0 = n_done;
        repeat (W + 3) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        @(posedge clk);
        #1;
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", busy, 0);
        @(posedge clk);
        #1;
        repeat (1000) begin
            a = W'($urandom);
            b = W'($urandom);
            r = ref_sub(a, b);
            run_op(a, b, r.diff, r.bout, r.ovf, 1'($urandom));
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b, LSB first, one bit per clock.
- Each bit goes through a single full-subtractor cell with a registered borrow.
- Counterpart to the combinational adder cells: trades area for WIDTH cycles of latency.
- Used where operands arrive in parallel but throughput needs are low. Reports borrow-out (unsigned underflow) and signed overflow.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
busy   output  1      high while bits are being processed (SHIFT state)
done   output  1      one-cycle pulse; diff/bout/ovf valid from this cycle onward
diff   output  WIDTH  result a - b mod 2^WIDTH
bout   output  1      final borrow; 1 iff a < b unsigned
ovf    output  1      signed overflow of two's-complement a - b

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE. busy, done, diff, bout, ovf and all internal registers are 0.
- Reset has priority over every other event, including start on the same edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - capture a into sa and b into sb; clear borrow br and count.
  - keep a[WIDTH-1] and b[WIDTH-1] for the overflow calculation.
  - go to SHIFT.
- IDLE, start=0: stay in IDLE; outputs hold their values.
- SHIFT, each edge:
  - d = sa[0] ^ sb[0] ^ br
  - br <= (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - internal result shift register r <= {d, r[WIDTH-1:1]}
  - sa and sb shift right by 1; count increments.
- Transition to DONE on the WIDTH-th SHIFT edge (edge E0+WIDTH). On that same edge:
  - diff <= final r (including the last d)
  - bout <= final borrow
  - ovf <= (a_msb != b_msb) && (final d != a_msb)
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Timing:
  - busy=1 exactly in the WIDTH cycles after edges E0..E0+WIDTH-1.
  - done=1 in the single cycle following edge E0+WIDTH.
  - Result latency is WIDTH+1 edges from acceptance until done is deasserted.
- start while busy or during DONE is ignored and not queued. The earliest next acceptance is the edge when state is IDLE.
- a and b may change freely after acceptance and do not affect the result in progress.
- diff, bout and ovf change only on the DONE-entry edge or on reset. Partial results are never visible on the outputs.
- Reset mid-operation: abort, return to IDLE, clear outputs, no done pulse.
- Arithmetic is purely modular; there are no special cases for a==b or for all-zero or all-one operands.

Decomposition:
- Shared package:
  - state enum/localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - count width function clog2(WIDTH+1)
- Sub-module full_subtractor, purely combinational: inputs x, y, bin; outputs d, bo.
  - d = x ^ y ^ bin
  - bo = (~x & y) | (~(x ^ y) & bin)
  - Instantiated once; the datapath registers and FSM live in serial_subtractor.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start one cycle -> busy high 8 cycles, then done pulse; diff=0x1E, bout=0, ovf=0; done exactly 9 edges after acceptance edge.
- a=0x00, b=0x01 -> diff=0xFF, bout=1, ovf=0; a=0x37, b=0x37 -> diff=0x00, bout=0, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
- Check start handling:
  - start held high continuously with changing a/b -> each operation uses the operands present at its acceptance edge.
  - start during busy/DONE is ignored; back-to-back accepts are spaced WIDTH+2 edges apart.
- Check reset cases:
  - rst asserted after 3 SHIFT edges -> next cycle busy=0, done never pulses, diff/bout/ovf=0.
  - A following start completes correctly.
  - rst and start on the same edge -> remain in IDLE.
- Random regression of 1000 operand pairs against the reference model (a-b) mod 256, borrow = a<b, signed overflow; also WIDTH=2 and WIDTH=16 builds.
